// File: rtl/deserialize.sv
`default_nettype none
// ============================================================================
// Module   : deserialize
// Purpose  : Serial-in, parallel-out receiver. Assembles MSB-first words of
//            WIDTH bits, with a valid strobe per word and an abort strobe.
// Revision : 1.0
// ============================================================================
module deserialize #(
    parameter int WIDTH = 4
) (
    input  logic                     input_input_switch1_clock_1,
    input  logic                     input_input_switch2_reset_2,
    input  logic                     input_input_switch3_shift_3,
    input  logic                     input_input_switch4_serial_4,
    output logic [WIDTH-1:0]         output_led1_q_5,
    output logic                     output_led2_valid_6,
    output logic                     output_led3_busy_7,
    output logic                     output_led4_abort_8,
    output logic [$clog2(WIDTH)-1:0] output_led5_count_9
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH - 1);

    logic             w_clk;
    logic             w_rst;
    logic             w_shift;
    logic             w_serial;

    logic [WIDTH-1:0] r_sr_q,    w_sr_d;
    logic [CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic [WIDTH-1:0] r_word_q,  w_word_d;
    logic             r_valid_q, w_valid_d;
    logic             r_abort_q, w_abort_d;

    assign w_clk    = input_input_switch1_clock_1;
    assign w_rst    = input_input_switch2_reset_2;
    assign w_shift  = input_input_switch3_shift_3;
    assign w_serial = input_input_switch4_serial_4;

    // cnt == 0 is the idle state; any other value means a partial word is held.
    always_comb begin
        w_sr_d    = r_sr_q;
        w_cnt_d   = r_cnt_q;
        w_word_d  = r_word_q;
        w_valid_d = 1'b0;
        w_abort_d = 1'b0;
        if (w_shift) begin
            if (r_cnt_q == C_LAST_CNT) begin
                w_word_d  = {r_sr_q[WIDTH-2:0], w_serial};
                w_valid_d = 1'b1;
                w_cnt_d   = '0;
                w_sr_d    = '0;
            end else begin
                w_sr_d  = {r_sr_q[WIDTH-2:0], w_serial};
                w_cnt_d = r_cnt_q + 1'b1;
            end
        end else if (r_cnt_q != '0) begin
            w_abort_d = 1'b1;
            w_cnt_d   = '0;
            w_sr_d    = '0;
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_sr_q    <= '0;
            r_cnt_q   <= '0;
            r_word_q  <= '0;
            r_valid_q <= 1'b0;
            r_abort_q <= 1'b0;
        end else begin
            r_sr_q    <= w_sr_d;
            r_cnt_q   <= w_cnt_d;
            r_word_q  <= w_word_d;
            r_valid_q <= w_valid_d;
            r_abort_q <= w_abort_d;
        end
    end

    assign output_led1_q_5     = r_word_q;
    assign output_led2_valid_6 = r_valid_q;
    assign output_led3_busy_7  = (r_cnt_q != '0);
    assign output_led4_abort_8 = r_abort_q;
    assign output_led5_count_9 = r_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_deserialize.sv
`default_nettype none
// ============================================================================
// Module   : tb_deserialize
// Purpose  : Self-checking bench for deserialize (WIDTH = 4), scoreboard based.
// Revision : 1.0
// ============================================================================
module tb_deserialize;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             shift;
    logic             serial;
    logic [WIDTH-1:0] q;
    logic             valid;
    logic             busy;
    logic             abort;
    logic [1:0]       count;

    int tests_run = 0;
    int failed    = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_sr;
    int               m_cnt;
    logic [WIDTH-1:0] m_q;

    deserialize #(.WIDTH(WIDTH)) dut (
        .input_input_switch1_clock_1 (clk),
        .input_input_switch2_reset_2 (rst),
        .input_input_switch3_shift_3 (shift),
        .input_input_switch4_serial_4(serial),
        .output_led1_q_5             (q),
        .output_led2_valid_6         (valid),
        .output_led3_busy_7          (busy),
        .output_led4_abort_8         (abort),
        .output_led5_count_9         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives n bits MSB-first from bits, checking every cycle against the model.
    task automatic test_shift_bits(input logic [15:0] bits, input int n, input string tag);
        logic             b;
        logic             exp_valid;
        logic [WIDTH-1:0] w;
        for (int i = 0; i < n; i++) begin
            b         = bits[n-1-i];
            shift     = 1'b1;
            serial    = b;
            m_sr      = {m_sr[WIDTH-2:0], b};
            m_cnt     = m_cnt + 1;
            exp_valid = 1'b0;
            if (m_cnt == WIDTH) begin
                exp_q.push_back(m_sr);
                m_q       = m_sr;
                m_cnt     = 0;
                exp_valid = 1'b1;
            end
            step();
            tests_run++;
            if (count !== 2'(m_cnt)) begin
                failed++;
                $display("FAIL %s count bit %0d: got %0d expected %0d", tag, i, count, m_cnt);
            end
            tests_run++;
            if (valid !== exp_valid || abort !== 1'b0) begin
                failed++;
                $display("FAIL %s strobes bit %0d: valid=%b abort=%b expected valid=%b abort=0",
                         tag, i, valid, abort, exp_valid);
            end
            tests_run++;
            if (busy !== (m_cnt != 0)) begin
                failed++;
                $display("FAIL %s busy bit %0d: got %b expected %b", tag, i, busy, (m_cnt != 0));
            end
            if (valid === 1'b1) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    failed++;
                    $display("FAIL %s unexpected word: got %b expected none", tag, q);
                end else begin
                    w = exp_q.pop_front();
                    if (q !== w) begin
                        failed++;
                        $display("FAIL %s word: got %b expected %b", tag, q, w);
                    end
                end
            end else begin
                tests_run++;
                if (q !== m_q) begin
                    failed++;
                    $display("FAIL %s q hold bit %0d: got %b expected %b", tag, i, q, m_q);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; shift = 1'b0; serial = 1'b0;
        step(); step();
        m_sr = '0; m_cnt = 0; m_q = '0;
        tests_run++;
        if (q !== 4'b0000 || valid !== 1'b0 || abort !== 1'b0 || busy !== 1'b0 || count !== 2'd0) begin
            failed++;
            $display("FAIL reset: q=%b valid=%b abort=%b busy=%b count=%0d expected all zero",
                     q, valid, abort, busy, count);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_word();
        test_shift_bits(16'b1011, 4, "single");
        shift = 1'b0;
        step();
        tests_run++;
        if (valid !== 1'b0 || q !== 4'b1011) begin
            failed++;
            $display("FAIL single after: valid=%b q=%b expected valid=0 q=1011", valid, q);
        end
    endtask

    task automatic test_back_to_back();
        test_shift_bits(16'b1100_0110, 8, "b2b");
        tests_run++;
        if (q !== 4'b0110) begin
            failed++;
            $display("FAIL b2b final q: got %b expected 0110", q);
        end
    endtask

    task automatic test_abort();
        test_shift_bits(16'b1011, 4, "abort_pre");
        test_shift_bits(16'b11, 2, "abort_part");
        shift = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (abort !== (i == 0) || valid !== 1'b0 || busy !== 1'b0 || count !== 2'd0 ||
                q !== 4'b1011) begin
                failed++;
                $display("FAIL abort cycle %0d: abort=%b valid=%b busy=%b count=%0d q=%b expected abort=%b q=1011",
                         i, abort, valid, busy, count, q, (i == 0));
            end
        end
        m_sr = '0; m_cnt = 0;
        test_shift_bits(16'b0001, 4, "abort_post");
    endtask

    task automatic test_reset_midword();
        test_shift_bits(16'b101, 3, "rstmid_part");
        rst = 1'b1; shift = 1'b1; serial = 1'b1;
        step();
        m_sr = '0; m_cnt = 0; m_q = '0;
        tests_run++;
        if (count !== 2'd0 || q !== 4'b0000 || valid !== 1'b0 || abort !== 1'b0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL rstmid: count=%0d q=%b valid=%b abort=%b busy=%b expected zeros",
                     count, q, valid, abort, busy);
        end
        rst = 1'b0;
        test_shift_bits(16'b1110, 4, "rstmid_post");
    endtask

    task automatic test_idle();
        shift = 1'b0;
        for (int i = 0; i < 10; i++) begin
            serial = i[0];
            step();
            tests_run++;
            if (q !== 4'b1110 || valid !== 1'b0 || abort !== 1'b0 || busy !== 1'b0 || count !== 2'd0) begin
                failed++;
                $display("FAIL idle cycle %0d: q=%b valid=%b abort=%b busy=%b count=%0d expected q=1110 rest 0",
                         i, q, valid, abort, busy, count);
            end
        end
    endtask

    initial begin
        rst = 1'b1; shift = 1'b0; serial = 1'b0;
        m_sr = '0; m_cnt = 0; m_q = '0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_abort();
        test_reset_midword();
        test_idle();
        tests_run++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard drain: %0d words outstanding expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
`default_nettype wire
